// File: rtl/ts4231_config_sequencer.sv
// ts4231_config_sequencer
// Power-up configuration controller for one TS4231 light-to-digital sensor.
// It waits for the sensor to report light (state S3, both pads high), then
// bit-bangs a 15-bit configuration word over the bidirectional D/E pads.
// Afterwards it puts the sensor into watch mode and hands the pads back to
// the darkroom decoder.
//
// Optional feature macro: TS4231_READBACK_VERIFY_EN
//   When defined, the word is read back after each write and compared.
//   A mismatch retries the write up to MAX_RETRIES times.
//   When undefined, there is no readback state and retry_cnt is tied to 0.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   start      in   1-cycle pulse, accepted only while idle (busy=0)
//   cfg_word   in   15-bit configuration word, captured on the accepted start
//   d_i, e_i   in   asynchronous pad inputs, 2-flop synchronised
//   d_o, d_oe  out  D pad drive value / output enable
//   e_o, e_oe  out  E pad drive value / output enable
//   busy       out  high from the accepted start until done or error
//   done       out  1-cycle pulse once the sensor is in watch mode
//   error      out  sticky failure flag, cleared by reset or the next start
//   retry_cnt  out  readback retries used in the current run
module ts4231_config_sequencer #(
    parameter int HALF_CYCLES    = 25,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [14:0] cfg_word,
    input  logic        d_i,
    input  logic        e_i,
    output logic        d_o,
    output logic        d_oe,
    output logic        e_o,
    output logic        e_oe,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  retry_cnt
);

    localparam int HW = $clog2(HALF_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [HW-1:0] PH_LAST = HW'(HALF_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_WATCH = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
`ifdef TS4231_READBACK_VERIFY_EN
    localparam logic [2:0] S_RBSHIFT = 3'd7;
`endif

    if (MAX_RETRIES > 3) begin : g_chk_retries
        $error("MAX_RETRIES exceeds the range of retry_cnt");
    end
    if (HALF_CYCLES < 2) begin : g_chk_half
        $error("HALF_CYCLES must be at least 2");
    end

    logic [2:0]    state_q, state_d;
    logic [1:0]    ph_q, ph_d;
    logic [HW-1:0] tmr_q, tmr_d;
    logic [TW-1:0] wt_q, wt_d;
    logic [3:0]    bit_q, bit_d;
    logic [14:0]   cfg_q, cfg_d;
    logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic          d_s1, d_s2, e_s1, e_s2;
    logic          phase_end, light;
`ifdef TS4231_READBACK_VERIFY_EN
    logic          rb_q, rb_d;
    logic [1:0]    retry_q, retry_d;
    logic [14:0]   shr_q, shr_d;
`endif

    assign phase_end = (tmr_q == PH_LAST);
    assign light     = e_s2 & d_s2;

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        wt_d    = wt_q;
        tmr_d   = phase_end ? '0 : tmr_q + 1'b1;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cfg_d   = cfg_q;
`ifdef TS4231_READBACK_VERIFY_EN
        rb_d    = rb_q;
        retry_d = retry_q;
        shr_d   = shr_q;
`endif
        case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (start) begin
                    state_d = S_WAIT;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    cfg_d   = cfg_word;
                    wt_d    = '0;
`ifdef TS4231_READBACK_VERIFY_EN
                    rb_d    = 1'b0;
                    retry_d = '0;
`endif
                end
            end
            // The phase timer doubles as the "light held" counter here.
            S_WAIT: begin
                if (light && phase_end) begin
                    state_d = S_START;
                    ph_d    = '0;
                end else if (wt_q == TO_LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    wt_d  = wt_q + 1'b1;
                    tmr_d = light ? tmr_q + 1'b1 : '0;
                end
            end
            S_START: if (phase_end) begin
                if (ph_q == 2'd2) begin
                    ph_d  = '0;
                    bit_d = 4'd14;
`ifdef TS4231_READBACK_VERIFY_EN
                    state_d = rb_q ? S_RBSHIFT : S_SHIFT;
`else
                    state_d = S_SHIFT;
`endif
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            // Two phases per bit: data with E low, then E high.
            S_SHIFT: if (phase_end) begin
                if (ph_q == 2'd0) begin
                    ph_d = 2'd1;
                end else begin
                    ph_d = '0;
                    if (bit_q == 4'd0) state_d = S_STOP;
                    else               bit_d = bit_q - 1'b1;
                end
            end
`ifdef TS4231_READBACK_VERIFY_EN
            // Sensor drives D; sample it on the last cycle of the E-high phase.
            S_RBSHIFT: if (phase_end) begin
                if (ph_q == 2'd0) begin
                    ph_d = 2'd1;
                end else begin
                    ph_d  = '0;
                    shr_d = {shr_q[13:0], d_s2};
                    if (bit_q == 4'd0) state_d = S_STOP;
                    else               bit_d = bit_q - 1'b1;
                end
            end
`endif
            S_STOP: if (phase_end) begin
                if (ph_q == 2'd2) begin
                    ph_d = '0;
`ifdef TS4231_READBACK_VERIFY_EN
                    if (!rb_q) begin
                        state_d = S_START;
                        rb_d    = 1'b1;
                    end else begin
                        rb_d = 1'b0;
                        if (shr_q == cfg_q) begin
                            state_d = S_WATCH;
                        end else if (int'(retry_q) < MAX_RETRIES) begin
                            retry_d = retry_q + 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            err_d   = 1'b1;
                        end
                    end
`else
                    state_d = S_WATCH;
`endif
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_WATCH: if (phase_end) begin
                if (ph_q == 2'd2) begin
                    ph_d    = '0;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            // Pads already released; busy stays high so a start here is ignored.
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            tmr_q   <= '0;
            wt_q    <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef TS4231_READBACK_VERIFY_EN
            rb_q    <= 1'b0;
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            tmr_q   <= tmr_d;
            wt_q    <= wt_d;
            bit_q   <= bit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef TS4231_READBACK_VERIFY_EN
            rb_q    <= rb_d;
            retry_q <= retry_d;
`endif
        end
    end

    // Pad synchronisers and data registers carry no reset.
    always_ff @(posedge clk) begin
        d_s1  <= d_i;
        d_s2  <= d_s1;
        e_s1  <= e_i;
        e_s2  <= e_s1;
        cfg_q <= cfg_d;
`ifdef TS4231_READBACK_VERIFY_EN
        shr_q <= shr_d;
`endif
    end

    // Pad levels are a pure decode of state and phase, so every transition
    // lands exactly on a phase boundary.
    always_comb begin
        d_o  = 1'b1;
        e_o  = 1'b1;
        d_oe = 1'b0;
        e_oe = 1'b0;
        case (state_q)
            S_START: begin
                d_oe = 1'b1; e_oe = 1'b1;
                d_o  = (ph_q == 2'd0);
                e_o  = (ph_q != 2'd2);
            end
            S_SHIFT: begin
                d_oe = 1'b1; e_oe = 1'b1;
                d_o  = cfg_q[bit_q];
                e_o  = ph_q[0];
            end
            S_STOP: begin
                d_oe = 1'b1; e_oe = 1'b1;
                d_o  = (ph_q == 2'd2);
                e_o  = (ph_q != 2'd0);
            end
            S_WATCH: begin
                d_oe = 1'b1; e_oe = 1'b1;
                d_o  = (ph_q != 2'd0);
                e_o  = (ph_q == 2'd2);
            end
`ifdef TS4231_READBACK_VERIFY_EN
            S_RBSHIFT: begin
                e_oe = 1'b1;
                e_o  = ph_q[0];
            end
`endif
            default: ;
        endcase
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign error = err_q;
`ifdef TS4231_READBACK_VERIFY_EN
    assign retry_cnt = retry_q;
`else
    assign retry_cnt = 2'b00;
`endif

endmodule

// File: tb/tb_ts4231_config_sequencer.sv
module tb_ts4231_config_sequencer;

    localparam int HC = 4;
    localparam int TO = 100;
    localparam int MR = 3;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [14:0] cfg_word;
    logic        d_i, e_i;
    logic        d_o, d_oe, e_o, e_oe, busy, done, error;
    logic [1:0]  retry_cnt;

    ts4231_config_sequencer #(
        .HALF_CYCLES(HC), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_word(cfg_word),
        .d_i(d_i), .e_i(e_i), .d_o(d_o), .d_oe(d_oe), .e_o(e_o), .e_oe(e_oe),
        .busy(busy), .done(done), .error(error), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sensor model: lit sensor holds both pads high; during readback it
    // answers each E rising edge with the next bit of rb_word.
    logic        light = 1'b1;
    logic        d_val = 1'b1;
    logic [14:0] rb_word = '0;
    int          rb_idx = 14;
    logic        rb_prev_e = 1'b0;
    assign d_i = light & d_val;
    assign e_i = light;

    always @(negedge clk) begin
        if (d_oe || !e_oe) begin
            rb_idx = 14;
            d_val  = 1'b1;
        end else if (e_o && !rb_prev_e) begin
            d_val  = (rb_idx >= 0) ? rb_word[rb_idx] : 1'b1;
            rb_idx = rb_idx - 1;
        end
        rb_prev_e = e_oe && e_o;
    end

    // Scoreboard of expected driven E rising edges: D level and spacing.
    typedef struct { logic d; int gap; } exp_t;
    exp_t sb[$];

    task automatic push_expect(input logic [14:0] w);
        exp_t x;
        for (int i = 14; i >= 0; i--) begin
            x.d   = w[i];
            x.gap = (i == 14) ? 4 * HC : 2 * HC;
            sb.push_back(x);
        end
        x.d = 1'b0; x.gap = 2 * HC;      // stop condition edge
        sb.push_back(x);
`ifndef TS4231_READBACK_VERIFY_EN
        x.d = 1'b1; x.gap = 4 * HC;      // watch-mode entry edge
        sb.push_back(x);
`endif
    endtask

    int   cyc = 0, last_edge = 0, done_cnt = 0, starts_cnt = 0;
    logic prev_eoe = 1'b0, prev_edrv = 1'b0, prev_ddrv = 1'b0;
    logic drv_seen = 1'b0, rb_seen = 1'b0;

    always @(negedge clk) begin
        exp_t ex;
        cyc++;
        if (d_oe || e_oe) drv_seen = 1'b1;
        if (e_oe && !d_oe) rb_seen = 1'b1;
        if (done) begin
            done_cnt++;
`ifndef TS4231_READBACK_VERIFY_EN
            check("done_after_watch", cyc - last_edge, HC);
`endif
        end
        if (e_oe && !prev_eoe) begin
            last_edge = cyc;
        end else if (e_oe && e_o && prev_eoe && !prev_edrv && d_oe && sb.size() > 0) begin
            ex = sb.pop_front();
            check("edge_d", d_o, ex.d);
            check("edge_gap", cyc - last_edge, ex.gap);
            last_edge = cyc;
        end
        if (d_oe && !d_o && e_oe && e_o && prev_ddrv && prev_edrv) starts_cnt++;
        prev_eoe  = e_oe;
        prev_edrv = e_oe && e_o;
        prev_ddrv = d_oe && d_o;
    end

    task automatic run_cfg(input logic [14:0] w, input bit poke);
        logic seen;
        int   d0;
        rb_word = w;
        d0      = done_cnt;
        rb_seen = 1'b0;
        push_expect(w);
        @(negedge clk); cfg_word = w; start = 1'b1;
        @(negedge clk); start = 1'b0; cfg_word = ~w;
        check("busy_on_start", busy, 1);
        check("err_cleared", error, 0);
        if (poke) begin
            repeat (30) @(negedge clk);
            cfg_word = 15'h0F0F; start = 1'b1;
            @(negedge clk); start = 1'b0;
            check("busy_poked", busy, 1);
        end
        seen = 1'b0;
        for (int n = 0; n < 4000 && !seen; n++) begin
            @(posedge clk); #1;
            seen = done;
        end
        check("done_seen", seen, 1);
        check("done_d_oe", d_oe, 0);
        check("done_e_oe", e_oe, 0);
        check("done_busy", busy, 1);
        check("done_error", error, 0);
        check("done_retry", retry_cnt, 0);
        start = 1'b1; cfg_word = w;      // lands on the done cycle
        @(posedge clk); #1; start = 1'b0;
        check("done_1clk", done, 0);
        check("busy_drop", busy, 0);
        repeat (4) @(posedge clk); #1;
        check("start_at_done_ignored", busy, 0);
        check("done_count", done_cnt - d0, 1);
        check("sb_drained", sb.size(), 0);
`ifndef TS4231_READBACK_VERIFY_EN
        check("no_readback", rb_seen, 0);
`endif
    endtask

    initial begin
        int n_to;
        reset = 1'b1; start = 1'b0; cfg_word = '0;
        repeat (3) @(posedge clk); #1;
        check("rst_d_o", d_o, 1);
        check("rst_e_o", e_o, 1);
        check("rst_d_oe", d_oe, 0);
        check("rst_e_oe", e_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_retry", retry_cnt, 0);
        @(negedge clk); reset = 1'b0;

        // Main write with a start pulse injected while busy.
        run_cfg(15'h392B, 1'b1);
        run_cfg(15'h4A5C, 1'b0);

        // Reset held mid-shift releases the pads on the next edge.
        @(negedge clk); cfg_word = 15'h1234; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (30) @(negedge clk);
        check("t1_driving", e_oe, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("t1_d_oe", d_oe, 0);
        check("t1_e_oe", e_oe, 0);
        check("t1_busy", busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        sb.delete();
        drv_seen = 1'b0;
        repeat (20) @(negedge clk);
        check("t1_quiet", drv_seen, 0);

        // Dark sensor: timeout flags error without touching the pads.
        light = 1'b0;
        repeat (4) @(negedge clk);
        drv_seen = 1'b0;
        cfg_word = 15'h392B; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        n_to = 0;
        for (int n = 1; n <= 300 && n_to == 0; n++) begin
            @(posedge clk); #1;
            if (error) n_to = n;
        end
        n_cmp++;
        assert (n_to >= TO && n_to <= TO + 3) else begin
            n_bad++;
            $error("FAIL timeout_latency: observed %0d expected %0d..%0d", n_to, TO, TO + 3);
        end
        check("to_busy", busy, 0);
        repeat (5) @(posedge clk); #1;
        check("to_sticky", error, 1);
        check("to_no_drive", drv_seen, 0);
        light = 1'b1;
        repeat (4) @(negedge clk);

        // New accepted start clears the sticky error and runs cleanly.
        run_cfg(15'h6D1E, 1'b0);

`ifdef TS4231_READBACK_VERIFY_EN
        // Readback always returns zero: every attempt (write start plus
        // readback start) fails until the retry budget is spent.
        begin
            int   s0, d0;
            logic err_seen;
            rb_word = 15'h0000;
            s0 = starts_cnt; d0 = done_cnt;
            @(negedge clk); cfg_word = 15'h392B; start = 1'b1;
            @(negedge clk); start = 1'b0;
            err_seen = 1'b0;
            for (int n = 0; n < 6000 && !err_seen; n++) begin
                @(posedge clk); #1;
                err_seen = error;
            end
            check("rb_error", err_seen, 1);
            check("rb_retry_cnt", retry_cnt, MR);
            check("rb_busy", busy, 0);
            check("rb_d_oe", d_oe, 0);
            check("rb_e_oe", e_oe, 0);
            check("rb_start_conds", starts_cnt - s0, 2 * (MR + 1));
            check("rb_no_done", done_cnt - d0, 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
